// File: rtl/arb_pkg.sv
// Shared constants for the eight-way round-robin selector:
// FSM state encoding, requester count, index width and the search helper.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int SELW = 3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  // First set request bit found scanning upward from p, wrapping at NREQ.
  function automatic logic [SELW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [SELW-1:0] p
  );
    logic [SELW-1:0] idx;
    logic [SELW-1:0] pick;
    logic            hit;
    pick = p;
    hit  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = p + SELW'(i);
      if (!hit && r[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_dec38.sv
// 3-to-8 one-hot decode of the selected index, gated by the valid flag.
// Yields an all-zero grant vector whenever no grant is active.
module arb_dec38
  import arb_pkg::*;
(
  input  logic [SELW-1:0] sel,
  input  logic            vld,
  output logic [NREQ-1:0] gnt
);

  // One-hot decode; at most one bit set by construction.
  always_comb begin
    gnt = '0;
    if (vld) gnt[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_sel_arb8.sv
// Round-robin selector for eight level-sensitive requesters (IDLE/GRANT/RELEASE).
// Optional grant timeout and timeout counter enabled by defining ARB_TIMEOUT_EN.
module rr_sel_arb8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            Enable,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [SELW-1:0] sel,
  output logic            sel_vld,
`ifdef ARB_TIMEOUT_EN
  output logic [7:0]      tmo_cnt,
`endif
  output logic [NREQ-1:0] gnt
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_illegal
    $error("rr_sel_arb8: MAX_HOLD must be in 1..255");
  end

  logic [1:0]      state;
  logic [SELW-1:0] ptr;
  logic            start;
  logic            in_grant;
  logic            tmo;
  logic            rel;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold;
  assign tmo = (hold == HOLD_LAST);
`else
  assign tmo = 1'b0;
`endif

  assign start    = (state == IDLE) && Enable && (|req);
  assign in_grant = (state == GRANT);
  assign rel      = in_grant && (done || !req[sel] || tmo);

  // Main FSM: arbitrate in IDLE, hold in GRANT, one forced dead cycle in RELEASE.
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      sel_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= GRANT;
            sel     <= rr_pick(req, ptr);
            sel_vld <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            state   <= RELEASE;
            sel_vld <= 1'b0;
            ptr     <= sel + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold length counter and saturating count of timeout-driven releases.
  always_ff @(posedge clk) begin
    if (RST) begin
      hold    <= '0;
      tmo_cnt <= '0;
    end else if (start) begin
      hold <= '0;
    end else if (in_grant) begin
      hold <= hold + 1'b1;
      if (rel && tmo && !done && tmo_cnt != 8'hFF)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

  arb_dec38 u_dec (
    .sel (sel),
    .vld (sel_vld),
    .gnt (gnt)
  );

endmodule

// File: tb/tb_rr_sel_arb8.sv
// Directed bench for rr_sel_arb8: cycle table plus multi-cycle sequences.
// Timeout checks are compiled in when ARB_TIMEOUT_EN is defined.
module tb_rr_sel_arb8;

  logic       clk = 1'b0;
  logic       RST;
  logic       Enable;
  logic       done;
  logic [7:0] req;
  logic [2:0] sel;
  logic       sel_vld;
  logic [7:0] gnt;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int gap;
  int n;

  always #5 clk = ~clk;

  rr_sel_arb8 dut (
    .clk     (clk),
    .RST     (RST),
    .Enable  (Enable),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .sel_vld (sel_vld),
`ifdef ARB_TIMEOUT_EN
    .tmo_cnt (tmo_cnt),
`endif
    .gnt     (gnt)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       vld;
    logic [7:0] gnt;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [7:0] q, input logic d);
    RST = r; Enable = e; req = q; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [7:0] q, output int g);
    g = 0;
    while (!sel_vld && g < 12) begin
      step(1'b0, 1'b1, q, 1'b0);
      g++;
    end
    if (!sel_vld) chk("wait_grant_timeout", 32'(sel_vld), 32'd1);
  endtask

  initial begin
    RST = 1'b1; Enable = 1'b0; req = 8'h00; done = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 8'h04, 1'b0, 3'd2, 1'b1, 8'h04};
    tbl[5]  = '{1'b0, 1'b1, 8'h04, 1'b0, 3'd2, 1'b1, 8'h04};
    tbl[6]  = '{1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 8'h04, 1'b0, 3'd2, 1'b1, 8'h04};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 8'h09, 1'b0, 3'd2, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 8'h09, 1'b0, 3'd3, 1'b1, 8'h08};
    tbl[12] = '{1'b0, 1'b0, 8'h09, 1'b0, 3'd3, 1'b1, 8'h08};
    tbl[13] = '{1'b0, 1'b0, 8'h18, 1'b0, 3'd3, 1'b1, 8'h08};
    tbl[14] = '{1'b0, 1'b0, 8'h18, 1'b1, 3'd3, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 8'h10, 1'b0, 3'd3, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 1'b0, 8'h10, 1'b0, 3'd3, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 1'b1, 8'h10, 1'b0, 3'd4, 1'b1, 8'h10};
    tbl[18] = '{1'b0, 1'b1, 8'h10, 1'b1, 3'd4, 1'b0, 8'h00};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].done);
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_vld", i), 32'(sel_vld), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
    end

    // Round robin with all requesters active
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    wait_grant(8'hFF, gap);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        wait_grant(8'hFF, gap);
        chk($sformatf("rr%0d_gap", k), 32'(gap), 32'd2);
      end
      chk($sformatf("rr%0d_sel", k), 32'(sel), 32'(k));
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'h1 << k);
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      chk($sformatf("rr%0d_rel", k), 32'(sel_vld), 32'd0);
    end

    // Wrap after last grant to 7
    wait_grant(8'h81, gap);
    chk("wrap_gap", 32'(gap), 32'd2);
    chk("wrap_sel0", 32'(sel), 32'd0);
    step(1'b0, 1'b1, 8'h81, 1'b1);
    wait_grant(8'h81, gap);
    chk("wrap_sel7", 32'(sel), 32'd7);
    chk("wrap_gnt7", 32'(gnt), 32'h80);
    step(1'b0, 1'b1, 8'h81, 1'b1);

    // Reset in the middle of a grant
    step(1'b1, 1'b1, 8'h00, 1'b0);
    wait_grant(8'h20, gap);
    chk("mid_sel5", 32'(sel), 32'd5);
    chk("mid_gnt5", 32'(gnt), 32'h20);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_vld", 32'(sel_vld), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("mid_next_sel", 32'(sel), 32'd0);
    chk("mid_next_gnt", 32'(gnt), 32'h01);

    // Long grant with done held low
    step(1'b1, 1'b1, 8'h00, 1'b0);
    wait_grant(8'h02, gap);
    chk("hold_sel", 32'(sel), 32'd1);
`ifdef ARB_TIMEOUT_EN
    chk("tmo_init", 32'(tmo_cnt), 32'd0);
    n = 1;
    while (sel_vld && n < 40) begin
      step(1'b0, 1'b1, 8'h02, 1'b0);
      if (sel_vld) n++;
    end
    chk("tmo_len", 32'(n), 32'd16);
    chk("tmo_cnt1", 32'(tmo_cnt), 32'd1);
    wait_grant(8'h02, gap);
    chk("tmo2_sel", 32'(sel), 32'd1);
    repeat (15) step(1'b0, 1'b1, 8'h02, 1'b0);
    chk("tmo2_still", 32'(sel_vld), 32'd1);
    step(1'b0, 1'b1, 8'h02, 1'b1);
    chk("tmo2_rel", 32'(sel_vld), 32'd0);
    chk("tmo2_cnt", 32'(tmo_cnt), 32'd1);
`else
    repeat (20) step(1'b0, 1'b1, 8'h02, 1'b0);
    chk("hold_vld", 32'(sel_vld), 32'd1);
    chk("hold_gnt", 32'(gnt), 32'h02);
    step(1'b0, 1'b1, 8'h02, 1'b1);
    chk("hold_rel", 32'(sel_vld), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
